// File: rtl/eth_manchester_rx.sv
// 10BASE-T Manchester receive decoder.
// The line is synchronised and its mid-bit transitions are recovered with a holdoff
// window. A preamble/SFD hunt then runs, and frame bytes are delivered LSB-first with
// start/end-of-frame strobes. Link pulses (NLP) never get past the preamble hunt.
//
// Output strobe semantics: rx_valid, rx_sof and rx_eof are single-cycle strobes.
// There is no back-pressure, so the consumer must accept a byte in the cycle
// rx_valid is high. rx_data stays stable until the next rx_valid. rx_err is
// meaningful only while rx_eof is high.
module eth_manchester_rx #(
  parameter int CLKS_PER_BIT = 10,
  parameter int HOLDOFF      = (CLKS_PER_BIT * 3) / 4,
  parameter int TIMEOUT      = (CLKS_PER_BIT * 3) / 2,
  parameter int PREAMBLE_MIN = 16,
  parameter bit INVERT       = 1'b0
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       eth_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_sof,
  output logic       rx_eof,
  output logic       rx_err,
  output logic       rx_active,
  output logic [1:0] dbg_state
);

  localparam int HW = $clog2(HOLDOFF + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HUNT = 2'd1,
    DATA = 2'd2
  } state_t;

  logic          s1_q, s2_q, hist_q;
  logic          s_w, edge_w, accept_w, tout_w;
  logic [HW-1:0] hold_q;
  logic [TW-1:0] tcnt_q;
  logic          bit_stb_q, bit_q, tout_q;

  state_t        state_q;
  logic [7:0]    cnt_q;
  logic          prev_q;
  logic [2:0]    bitcnt_q;
  logic [7:0]    shift_q;
  logic [7:0]    rx_data_q;
  logic          rx_valid_q, rx_sof_q, rx_eof_q, rx_err_q, rx_active_q;

  // An edge is accepted only outside the holdoff window. This rejects bit-boundary
  // transitions. The timeout is reported only when no edge arrives in that cycle,
  // so an edge wins over a timeout.
  assign s_w      = s2_q ^ INVERT;
  assign edge_w   = (s_w != hist_q);
  assign accept_w = edge_w && (hold_q == '0);
  assign tout_w   = (tcnt_q == TW'(TIMEOUT)) && !accept_w;

  // Two-flop synchroniser plus one-flop history for edge detection.
  // The history flop resets to the idle level so no edge is seen after reset.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      hist_q <= INVERT;
    end else begin
      s1_q   <= eth_rx;
      s2_q   <= s1_q;
      hist_q <= s_w;
    end
  end

  // Bit recovery runs the holdoff and carrier timers.
  // It registers the bit strobe (the new level) and the timeout level.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      hold_q    <= '0;
      tcnt_q    <= '0;
      bit_stb_q <= 1'b0;
      bit_q     <= 1'b0;
      tout_q    <= 1'b0;
    end else begin
      bit_stb_q <= accept_w;
      bit_q     <= s_w;
      tout_q    <= tout_w;
      if (accept_w) begin
        hold_q <= HW'(HOLDOFF);
        tcnt_q <= '0;
      end else begin
        if (hold_q != '0) hold_q <= hold_q - HW'(1);
        if (tcnt_q != TW'(TIMEOUT)) tcnt_q <= tcnt_q + TW'(1);
      end
    end
  end

  // Frame FSM covers the preamble/SFD hunt and byte assembly. All outputs are registered.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      prev_q      <= 1'b0;
      bitcnt_q    <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      rx_sof_q    <= 1'b0;
      rx_eof_q    <= 1'b0;
      rx_err_q    <= 1'b0;
      rx_active_q <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      rx_sof_q   <= 1'b0;
      rx_eof_q   <= 1'b0;
      rx_err_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          // rx_active drops one cycle after rx_eof.
          rx_active_q <= 1'b0;
          if (bit_stb_q) begin
            state_q <= HUNT;
            cnt_q   <= 8'd1;
            prev_q  <= bit_q;
          end
        end
        HUNT: begin
          if (bit_stb_q) begin
            prev_q <= bit_q;
            if (bit_q != prev_q) begin
              if (cnt_q != 8'd255) cnt_q <= cnt_q + 8'd1;
            end else if (prev_q && bit_q && (cnt_q >= 8'(PREAMBLE_MIN))) begin
              // Two consecutive ones after a long enough alternating run mark the SFD.
              state_q     <= DATA;
              rx_sof_q    <= 1'b1;
              rx_active_q <= 1'b1;
              bitcnt_q    <= '0;
              shift_q     <= '0;
            end else begin
              cnt_q <= 8'd1;
            end
          end else if (tout_q) begin
            state_q <= IDLE;
          end
        end
        DATA: begin
          if (bit_stb_q) begin
            shift_q <= {bit_q, shift_q[7:1]};
            if (bitcnt_q == 3'd7) begin
              rx_data_q  <= {bit_q, shift_q[7:1]};
              rx_valid_q <= 1'b1;
              bitcnt_q   <= '0;
            end else begin
              bitcnt_q <= bitcnt_q + 3'd1;
            end
          end else if (tout_q) begin
            // A single trailing bit is the TP_IDL artefact and is not an error.
            rx_eof_q <= 1'b1;
            rx_err_q <= (bitcnt_q >= 3'd2);
            bitcnt_q <= '0;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign rx_sof    = rx_sof_q;
  assign rx_eof    = rx_eof_q;
  assign rx_err    = rx_err_q;
  assign rx_active = rx_active_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_eth_manchester_rx.sv
// Bench for eth_manchester_rx: drives an ideal or jittered Manchester line and
// checks the strobe counts, the byte stream and the output invariants.
module tb_eth_manchester_rx;

  logic       CLK;
  logic       RST_N;
  logic       eth_rx;
  logic [7:0] rx_data;
  logic       rx_valid, rx_sof, rx_eof, rx_err, rx_active;
  logic [1:0] dbg_state;

  eth_manchester_rx dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .eth_rx    (eth_rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_sof    (rx_sof),
    .rx_eof    (rx_eof),
    .rx_err    (rx_err),
    .rx_active (rx_active),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #3000000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

  // ---------------- bookkeeping ----------------
  int total = 0;
  int bad   = 0;
  int n_sof = 0, n_val = 0, n_eof = 0, n_err = 0, viol = 0;
  logic [7:0] exp_q[$];
  logic [7:0] last_data = 8'h00;
  logic       act_m = 1'b0;
  logic [7:0] tx_buf [0:127];
  bit         jit_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  always @(negedge CLK) begin
    logic       act_exp;
    logic [7:0] eb;
    if (!RST_N) begin
      if (rx_valid || rx_sof || rx_eof || rx_err || rx_active || (rx_data != 8'h00)) viol++;
      act_m     = 1'b0;
      last_data = 8'h00;
    end else begin
      if (rx_sof) n_sof++;
      if (rx_eof) n_eof++;
      if (rx_err) n_err++;
      if (rx_valid) begin
        n_val++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_byte actual=%0h required=none", rx_data);
        end else begin
          eb = exp_q.pop_front();
          check("rx_byte", 32'(rx_data), 32'(eb));
        end
        last_data = rx_data;
      end else if (rx_data != last_data) begin
        viol++;
      end
      if (rx_valid && rx_eof) viol++;
      if (rx_sof && rx_valid) viol++;
      if (rx_err && !rx_eof) viol++;
      act_exp = act_m | rx_sof;
      if (rx_active != act_exp) viol++;
      act_m = rx_eof ? 1'b0 : act_exp;
    end
  end

  // ---------------- driver tasks ----------------
  // One Manchester bit: first half ~b, second half b (mid-bit edge carries b).
  task automatic tx_bit(input logic b);
    int p;
    p = jit_en ? int'($urandom_range(114, 86)) : 100;
    eth_rx = ~b;
    #(p / 2);
    eth_rx = b;
    #(p - p / 2);
  endtask

  task automatic tx_frame(input int pre_len, input int nb, input int nx,
                          input logic [7:0] xb, input bit tpidl);
    logic [7:0] sfd;
    logic [7:0] cur;
    sfd = 8'hD5;
    for (int i = 0; i < pre_len; i++) tx_bit((i % 2) == 0);
    for (int i = 0; i < 8; i++) tx_bit(sfd[i]);
    for (int k = 0; k < nb; k++) begin
      cur = tx_buf[k];
      for (int i = 0; i < 8; i++) tx_bit(cur[i]);
    end
    for (int i = 0; i < nx; i++) tx_bit(xb[i]);
    if (tpidl) begin
      eth_rx = 1'b1;
      #200;
    end
    eth_rx = 1'b0;
  endtask

  task automatic settle(input int cycles);
    repeat (cycles) @(posedge CLK);
    #2;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int         pre;
    int         nb;
    logic [7:0] b0;
    logic [7:0] b1;
    int         nx;
    logic [7:0] xb;
    bit         tpidl;
    int         e_sof;
    int         e_val;
    int         e_eof;
    int         e_err;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int b_sof, b_val, b_eof, b_err, b_viol, budget, nrand;
    logic [7:0] r;

    // pre, nb, b0, b1, extra bits, extra pattern, tp_idl -> sof, valid, eof, err
    vecs[0] = '{56, 2, 8'hA5, 8'h3C, 0, 8'h00, 1'b1, 1, 2, 1, 0};
    // 8 preamble bits + 7 alternating SFD bits = run of 15, below the minimum
    vecs[1] = '{8,  1, 8'h55, 8'h00, 0, 8'h00, 1'b1, 0, 0, 0, 0};
    vecs[2] = '{56, 1, 8'hA5, 8'h00, 3, 8'h05, 1'b0, 1, 1, 1, 1};
    vecs[3] = '{56, 2, 8'h00, 8'hFF, 1, 8'h01, 1'b0, 1, 2, 1, 0};
    vecs[4] = '{56, 1, 8'h81, 8'h00, 7, 8'h2A, 1'b0, 1, 1, 1, 1};
    vecs[5] = '{56, 2, 8'h12, 8'hED, 2, 8'h03, 1'b0, 1, 2, 1, 1};

    RST_N  = 1'b0;
    eth_rx = 1'b0;
    repeat (5) @(posedge CLK);
    #2;
    check("reset_outputs", 32'({rx_valid, rx_sof, rx_eof, rx_err, rx_active, rx_data, dbg_state}), 32'(0));
    RST_N = 1'b1;
    settle(20);
    check("idle_after_reset", 32'({rx_valid, rx_sof, rx_eof, rx_active, dbg_state}), 32'(0));

    // ---- table-driven frames ----
    for (int v = 0; v < 6; v++) begin
      tx_buf[0] = vecs[v].b0;
      tx_buf[1] = vecs[v].b1;
      if (vecs[v].e_val > 0) exp_q.push_back(vecs[v].b0);
      if (vecs[v].e_val > 1) exp_q.push_back(vecs[v].b1);
      b_sof = n_sof; b_val = n_val; b_eof = n_eof; b_err = n_err; b_viol = viol;
      tx_frame(vecs[v].pre, vecs[v].nb, vecs[v].nx, vecs[v].xb, vecs[v].tpidl);
      settle(300);
      check($sformatf("v%0d_sof", v), 32'(n_sof - b_sof), 32'(vecs[v].e_sof));
      check($sformatf("v%0d_valid", v), 32'(n_val - b_val), 32'(vecs[v].e_val));
      check($sformatf("v%0d_eof", v), 32'(n_eof - b_eof), 32'(vecs[v].e_eof));
      check($sformatf("v%0d_err", v), 32'(n_err - b_err), 32'(vecs[v].e_err));
      check($sformatf("v%0d_bytes_left", v), 32'(exp_q.size()), 32'(0));
      check($sformatf("v%0d_invariants", v), 32'(viol - b_viol), 32'(0));
      check($sformatf("v%0d_state", v), 32'(dbg_state), 32'(0));
      exp_q.delete();
    end

    // ---- NLP train: 20 single 100 ns pulses every 2 us ----
    b_sof = n_sof; b_val = n_val; b_eof = n_eof; b_viol = viol;
    for (int i = 0; i < 20; i++) begin
      eth_rx = 1'b1;
      #100;
      eth_rx = 1'b0;
      #1900;
    end
    settle(100);
    check("nlp_strobes", 32'((n_sof - b_sof) + (n_val - b_val) + (n_eof - b_eof)), 32'(0));
    check("nlp_state", 32'(dbg_state), 32'(0));
    check("nlp_invariants", 32'(viol - b_viol), 32'(0));

    // ---- 64 random bytes with bit jitter and async phase ----
    nrand = 64;
    for (int k = 0; k < nrand; k++) begin
      r = 8'($urandom_range(255, 0));
      tx_buf[k] = r;
      exp_q.push_back(r);
    end
    b_sof = n_sof; b_val = n_val; b_eof = n_eof; b_err = n_err; b_viol = viol;
    #($urandom_range(9, 1));
    jit_en = 1'b1;
    tx_frame(56, nrand, 0, 8'h00, 1'b1);
    jit_en = 1'b0;
    settle(300);
    check("jit_sof", 32'(n_sof - b_sof), 32'(1));
    check("jit_valid", 32'(n_val - b_val), 32'(nrand));
    check("jit_eof", 32'(n_eof - b_eof), 32'(1));
    check("jit_err", 32'(n_err - b_err), 32'(0));
    check("jit_bytes_left", 32'(exp_q.size()), 32'(0));
    check("jit_invariants", 32'(viol - b_viol), 32'(0));
    exp_q.delete();

    // ---- reset after the second byte of a frame ----
    tx_buf[0] = 8'h11; tx_buf[1] = 8'h22; tx_buf[2] = 8'h33; tx_buf[3] = 8'h44;
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    b_sof = n_sof; b_val = n_val; b_eof = n_eof; b_viol = viol;
    fork
      tx_frame(56, 4, 0, 8'h00, 1'b0);
      begin
        budget = 0;
        while ((n_val - b_val) < 2 && budget < 5000) begin
          @(posedge CLK);
          budget++;
        end
        check("rst_two_bytes_seen", 32'(n_val - b_val), 32'(2));
        @(posedge CLK);
        #2;
        RST_N = 1'b0;
        @(negedge CLK);
        check("rst_mid_outputs", 32'({rx_valid, rx_sof, rx_eof, rx_err, rx_active, rx_data, dbg_state}), 32'(0));
        repeat (3) @(posedge CLK);
        #2;
        RST_N = 1'b1;
      end
    join
    settle(300);
    check("rst_no_eof", 32'(n_eof - b_eof), 32'(0));
    check("rst_valid_total", 32'(n_val - b_val), 32'(2));
    check("rst_sof_total", 32'(n_sof - b_sof), 32'(1));
    check("rst_state", 32'(dbg_state), 32'(0));
    check("rst_invariants", 32'(viol - b_viol), 32'(0));
    exp_q.delete();

    tx_buf[0] = 8'h5A; tx_buf[1] = 8'hC3; tx_buf[2] = 8'h0F;
    exp_q.push_back(8'h5A);
    exp_q.push_back(8'hC3);
    exp_q.push_back(8'h0F);
    b_sof = n_sof; b_val = n_val; b_eof = n_eof; b_err = n_err; b_viol = viol;
    tx_frame(56, 3, 0, 8'h00, 1'b1);
    settle(300);
    check("post_rst_sof", 32'(n_sof - b_sof), 32'(1));
    check("post_rst_valid", 32'(n_val - b_val), 32'(3));
    check("post_rst_eof", 32'(n_eof - b_eof), 32'(1));
    check("post_rst_err", 32'(n_err - b_err), 32'(0));
    check("post_rst_bytes_left", 32'(exp_q.size()), 32'(0));
    check("post_rst_invariants", 32'(viol - b_viol), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
